// File: rtl/cipher_vault_pkg.sv
// cipher_vault_pkg
// Shared definitions for the cipher vault: FSM state and response status
// encodings, alphabet constants (base 48, modulus 43, last symbol 90), the
// per-request chaining seed, and an alphabet membership helper.
package cipher_vault_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ENC,
        ST_LOOKUP,
        ST_DEC,
        ST_RESP
    } vault_state_t;

    typedef enum logic [1:0] {
        RSP_OK      = 2'd0,
        RSP_NOMATCH = 2'd1,
        RSP_REJECT  = 2'd2,
        RSP_LOCKED  = 2'd3
    } rsp_status_t;

    localparam logic [7:0] ALPHA_BASE = 8'd48;
    localparam logic [7:0] ALPHA_LAST = 8'd90;
    localparam int         ALPHA_MOD  = 43;
    localparam logic [5:0] PREV_SEED  = 6'd5;

    function automatic logic in_alphabet(input logic [7:0] b);
        return (b >= ALPHA_BASE) && (b <= ALPHA_LAST);
    endfunction

endpackage

// File: rtl/vault_byte_cipher.sv
// vault_byte_cipher
// Combinational single-byte chained substitution over the 43-symbol alphabet.
// Ports:
//   mode     in  0 = encrypt, 1 = decrypt
//   byte_in  in  plaintext (encrypt) or ciphertext (decrypt) byte
//   key      in  8-bit key
//   prev     in  alphabet index of the previous plaintext byte
//   byte_out out mapped byte (zero passes through as zero)
//   prev_out out chaining index for the next byte (unchanged on zero)
module vault_byte_cipher
    import cipher_vault_pkg::*;
(
    input  logic       mode,
    input  logic [7:0] byte_in,
    input  logic [7:0] key,
    input  logic [5:0] prev,
    output logic [7:0] byte_out,
    output logic [5:0] prev_out
);

    localparam logic signed [10:0] MOD_S = 11'(ALPHA_MOD);

    // Non-negative remainder of a signed sum; 11 bits covers -366..525.
    function automatic logic [5:0] mod_alpha(input logic signed [10:0] x);
        logic signed [10:0] r;
        r = x % MOD_S;
        if (r < 0) r = r + MOD_S;
        return r[5:0];
    endfunction

    logic signed [10:0] idx_s;
    logic signed [10:0] key_s;
    logic signed [10:0] prev_s;
    logic signed [10:0] sum_s;
    logic        [5:0]  res_idx;

    always_comb begin
        idx_s    = $signed({3'b000, byte_in}) - $signed({3'b000, ALPHA_BASE});
        key_s    = $signed({3'b000, key});
        prev_s   = $signed({5'b00000, prev});
        sum_s    = mode ? (idx_s - key_s - prev_s) : (idx_s + key_s + prev_s);
        res_idx  = mod_alpha(sum_s);
        byte_out = 8'd0;
        prev_out = prev;
        if (byte_in != 8'd0) begin
            byte_out = ALPHA_BASE + {2'b00, res_idx};
            // chaining always follows the plaintext index
            prev_out = mode ? res_idx : idx_s[5:0];
        end
    end

endmodule

// File: rtl/cipher_vault.sv
// cipher_vault
// Encrypts codes into a small store of {ciphertext, key} entries and decrypts
// a ciphertext only when it is found in the store with the same key. Repeated
// failed decrypts lock the vault until reset.
// Ports:
//   msclk, rst_n          clock, asynchronous active-low reset
//   req_valid/req_ready   request handshake (ready only when idle)
//   req_op, key, code_in  0 = encrypt / 1 = decrypt, key, code (top byte first)
//   rsp_valid             one-cycle response pulse
//   rsp_status, code_out  status (OK/NOMATCH/REJECT/LOCKED) and held result
//   tries_left, locked    remaining failures before lockout, lockout flag
// Build option: define CIPHER_VAULT_EVICT_EN to let encrypts overwrite the
// oldest entry once the store is full; otherwise a full store rejects.
module cipher_vault
    import cipher_vault_pkg::*;
#(
    parameter int NBYTES = 10,
    parameter int DEPTH  = 10,
    parameter int TRIES  = 3
) (
    input  logic                  msclk,
    input  logic                  rst_n,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_op,
    input  logic [7:0]            key,
    input  logic [8*NBYTES-1:0]   code_in,
    output logic                  rsp_valid,
    output logic [1:0]            rsp_status,
    output logic [8*NBYTES-1:0]   code_out,
    output logic [3:0]            tries_left,
    output logic                  locked
);

    localparam int CW    = 8 * NBYTES;
    localparam int CMAX  = (NBYTES > DEPTH) ? NBYTES : DEPTH;
    localparam int CNT_W = $clog2(CMAX);
    localparam int PTR_W = $clog2(DEPTH);

    vault_state_t     state_q, state_d;
    logic [CNT_W-1:0] cnt_q;
    logic [PTR_W-1:0] wr_ptr_q;
    logic [DEPTH-1:0] valid_q;
    logic [3:0]       fail_q;
    logic             locked_q;
    logic             bad_q;
    logic             hit_q;
    rsp_status_t      status_q;
    logic [CW-1:0]    code_out_q;

    logic [CW-1:0]    work_q;
    logic [7:0]       key_q;
    logic [5:0]       prev_q;
    logic [CW-1:0]    cipher_mem [DEPTH];
    logic [7:0]       key_mem    [DEPTH];

    logic             accept;
    logic             last_byte;
    logic             last_entry;
    logic             cur_bad;
    logic             cur_match;
    logic             hit_any;
    logic             store_blocked;
    logic             enc_reject;
    logic             store_en;
    logic [7:0]       top_byte;
    logic [7:0]       byte_res;
    logic [5:0]       prev_nxt;
    logic [CW-1:0]    work_nxt;
    logic [PTR_W-1:0] scan_idx;

    assign accept     = (state_q == ST_IDLE) && req_valid;
    assign last_byte  = (cnt_q == CNT_W'(NBYTES - 1));
    assign last_entry = (cnt_q == CNT_W'(DEPTH - 1));
    assign top_byte   = work_q[CW-1 -: 8];
    assign cur_bad    = (top_byte != 8'd0) && !in_alphabet(top_byte);
    // work register shifts left; results enter at the bottom, so after all
    // bytes the result sits in the original byte order
    assign work_nxt   = (work_q << 8) | CW'(byte_res);
    assign scan_idx   = cnt_q[PTR_W-1:0];
    assign cur_match  = (state_q == ST_LOOKUP) && valid_q[scan_idx] &&
                        (cipher_mem[scan_idx] == work_q) && (key_mem[scan_idx] == key_q);
    assign hit_any    = hit_q | cur_match;

`ifdef CIPHER_VAULT_EVICT_EN
    assign store_blocked = 1'b0;
`else
    assign store_blocked = &valid_q;
`endif

    assign enc_reject = bad_q | cur_bad | store_blocked;
    assign store_en   = (state_q == ST_ENC) && last_byte && !enc_reject;

    vault_byte_cipher u_byte (
        .mode     (state_q == ST_DEC),
        .byte_in  (top_byte),
        .key      (key_q),
        .prev     (prev_q),
        .byte_out (byte_res),
        .prev_out (prev_nxt)
    );

    always_ff @(posedge msclk or negedge rst_n) begin
        if (!rst_n) state_q <= ST_IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:   if (req_valid) state_d = locked_q ? ST_RESP : (req_op ? ST_LOOKUP : ST_ENC);
            ST_ENC:    if (last_byte) state_d = ST_RESP;
            ST_LOOKUP: if (last_entry) state_d = hit_any ? ST_DEC : ST_RESP;
            ST_DEC:    if (last_byte) state_d = ST_RESP;
            ST_RESP:   state_d = ST_IDLE;
            default:   state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        req_ready = (state_q == ST_IDLE);
        rsp_valid = (state_q == ST_RESP);
    end

    always_ff @(posedge msclk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q      <= '0;
            wr_ptr_q   <= '0;
            valid_q    <= '0;
            fail_q     <= '0;
            locked_q   <= 1'b0;
            bad_q      <= 1'b0;
            hit_q      <= 1'b0;
            status_q   <= RSP_OK;
            code_out_q <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    cnt_q <= '0;
                    bad_q <= 1'b0;
                    hit_q <= 1'b0;
                    if (req_valid && locked_q) begin
                        status_q   <= RSP_LOCKED;
                        code_out_q <= '0;
                    end
                end
                ST_ENC: begin
                    cnt_q <= cnt_q + 1'b1;
                    bad_q <= bad_q | cur_bad;
                    if (last_byte) begin
                        if (enc_reject) begin
                            status_q   <= RSP_REJECT;
                            code_out_q <= '0;
                        end else begin
                            status_q          <= RSP_OK;
                            code_out_q        <= work_nxt;
                            valid_q[wr_ptr_q] <= 1'b1;
                            wr_ptr_q          <= (wr_ptr_q == PTR_W'(DEPTH - 1)) ? '0 : wr_ptr_q + 1'b1;
                        end
                    end
                end
                ST_LOOKUP: begin
                    // the scan always covers every entry so timing never
                    // depends on where (or whether) a match is found
                    cnt_q <= last_entry ? '0 : cnt_q + 1'b1;
                    hit_q <= hit_any;
                    if (last_entry && !hit_any) begin
                        status_q   <= RSP_NOMATCH;
                        code_out_q <= '0;
                        fail_q     <= fail_q + 4'd1;
                        if (fail_q + 4'd1 == 4'(TRIES)) locked_q <= 1'b1;
                    end
                end
                ST_DEC: begin
                    cnt_q <= cnt_q + 1'b1;
                    if (last_byte) begin
                        status_q   <= RSP_OK;
                        code_out_q <= work_nxt;
                        fail_q     <= '0;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge msclk) begin
        if (accept) begin
            work_q <= code_in;
            key_q  <= key;
            prev_q <= PREV_SEED;
        end else if ((state_q == ST_ENC) || (state_q == ST_DEC)) begin
            work_q <= work_nxt;
            prev_q <= prev_nxt;
        end
        if (store_en) begin
            cipher_mem[wr_ptr_q] <= work_nxt;
            key_mem[wr_ptr_q]    <= key_q;
        end
    end

    assign rsp_status = status_q;
    assign code_out   = code_out_q;
    assign tries_left = 4'(TRIES) - fail_q;
    assign locked     = locked_q;

endmodule
